// File: rtl/ram_cmd_sequencer.sv
// ram_cmd_sequencer
//
// Turns single host read/write requests into the RAM command sequence
// (PRE / ACT / RD / WR) with activate, precharge and read-latency spacing,
// streams write beats onto datain and registers read beats from dataout.
// An 8-entry open-row table ({bank_grp, bank_no}) enables row-hit reuse.
//
// Optional feature: define RAM_AUTO_PRE_EN to issue every RD/WR with
// auto-precharge (closed-page policy, TRP wait in POST_RP before IDLE).
//
// Ports:
//   clk_t, reset                  clock, async active-high reset
//   req_valid/req_ready           host request handshake
//   req_rwb, req_bank_grp, req_bank_no, req_row, req_col, req_burst_len
//                                 request fields (burst_len = beats - 1)
//   wr_pull, wr_data              write beat taken / write beat from host
//   rd_valid, rd_data             read beat to host
//   cke, cs, act, rwb, auto_pre, bank_grp, burst_mode, bank_no,
//   row_address, col_address, burst_len, datain
//                                 RAM command/data outputs
//   dataout                       RAM read data
module ram_cmd_sequencer #(
  parameter int unsigned TRCD = 2,
  parameter int unsigned TRP  = 2,
  parameter int unsigned RL   = 3
) (
  input  logic        clk_t,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rwb,
  input  logic        req_bank_grp,
  input  logic [1:0]  req_bank_no,
  input  logic [2:0]  req_row,
  input  logic [2:0]  req_col,
  input  logic [2:0]  req_burst_len,
  output logic        wr_pull,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        cke,
  output logic        cs,
  output logic        act,
  output logic        rwb,
  output logic        auto_pre,
  output logic        bank_grp,
  output logic        burst_mode,
  output logic [1:0]  bank_no,
  output logic [2:0]  row_address,
  output logic [2:0]  col_address,
  output logic [2:0]  burst_len,
  output logic [15:0] datain,
  input  logic [15:0] dataout
);

  localparam int unsigned CntW = 8;

  typedef enum logic [3:0] {
    StIdle, StPre, StWaitRp, StAct, StWaitRcd, StCmd,
    StWrXfer, StRdWait, StRdXfer, StPostRp
  } state_e;

`ifdef RAM_AUTO_PRE_EN
  localparam bit     AutoPre = 1'b1;
  localparam state_e StDone  = StPostRp;
`else
  localparam bit     AutoPre = 1'b0;
  localparam state_e StDone  = StIdle;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cke_q;

  logic              cap_rwb_q, cap_bg_q;
  logic [1:0]        cap_bank_q;
  logic [2:0]        cap_row_q, cap_col_q, cap_bl_q;

  logic [7:0]        open_q;
  logic [2:0]        row_q [8];

  logic              rd_valid_q;
  logic [15:0]       rd_data_q;

  logic              accept;
  logic [2:0]        req_idx, cap_idx;
  logic              bank_open, row_hit;

  assign req_idx   = {req_bank_grp, req_bank_no};
  assign cap_idx   = {cap_bg_q, cap_bank_q};
  assign bank_open = open_q[req_idx];
  assign row_hit   = bank_open && (row_q[req_idx] == req_row);

  // cke_q only rises on the first edge after reset release, which also gates req_ready
  assign req_ready = cke_q && (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // Next-state logic. Wait states load cnt with (cycles - 1) and leave at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (row_hit)        state_d = StCmd;
          else if (bank_open) state_d = StPre;
          else                state_d = StAct;
        end
      end
      StPre: begin
        if (TRP == 1) begin
          state_d = StAct;
        end else begin
          state_d = StWaitRp;
          cnt_d   = CntW'(TRP - 2);
        end
      end
      StWaitRp: begin
        if (cnt_q == '0) state_d = StAct;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StAct: begin
        if (TRCD == 1) begin
          state_d = StCmd;
        end else begin
          state_d = StWaitRcd;
          cnt_d   = CntW'(TRCD - 2);
        end
      end
      StWaitRcd: begin
        if (cnt_q == '0) state_d = StCmd;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StCmd: begin
        if (cap_rwb_q) begin
          if (RL == 1) begin
            state_d = StRdXfer;
            cnt_d   = CntW'(cap_bl_q);
          end else begin
            state_d = StRdWait;
            cnt_d   = CntW'(RL - 2);
          end
        end else if (cap_bl_q == 3'd0) begin
          state_d = StDone;
          cnt_d   = CntW'(TRP - 1);
        end else begin
          // CMD carries beat 0, WR_XFER the remaining burst_len beats
          state_d = StWrXfer;
          cnt_d   = CntW'(cap_bl_q - 3'd1);
        end
      end
      StWrXfer, StRdXfer: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          cnt_d   = CntW'(TRP - 1);
        end else begin
          cnt_d   = cnt_q - CntW'(1);
        end
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          state_d = StRdXfer;
          cnt_d   = CntW'(cap_bl_q);
        end else begin
          cnt_d   = cnt_q - CntW'(1);
        end
      end
      StPostRp: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Command/data outputs decoded from the current state
  always_comb begin
    cs          = 1'b0;
    act         = 1'b0;
    auto_pre    = 1'b0;
    rwb         = 1'b0;
    col_address = 3'd0;
    burst_len   = 3'd0;
    wr_pull     = 1'b0;
    bank_grp    = 1'b0;
    bank_no     = 2'd0;
    row_address = 3'd0;
    if (state_q != StIdle) begin
      bank_grp    = cap_bg_q;
      bank_no     = cap_bank_q;
      row_address = cap_row_q;
    end
    unique case (state_q)
      StPre: begin
        cs       = 1'b1;
        act      = 1'b1;
        auto_pre = 1'b1;
      end
      StAct: begin
        cs  = 1'b1;
        act = 1'b1;
      end
      StCmd: begin
        cs          = 1'b1;
        rwb         = cap_rwb_q;
        auto_pre    = AutoPre;
        col_address = cap_col_q;
        burst_len   = cap_bl_q;
        wr_pull     = !cap_rwb_q;
      end
      StWrXfer: wr_pull = 1'b1;
      default: ;
    endcase
  end

  assign burst_mode = (burst_len != 3'd0);
  assign datain     = wr_pull ? wr_data : 16'd0;
  assign cke        = cke_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

  always_ff @(posedge clk_t or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cke_q      <= 1'b0;
      cap_rwb_q  <= 1'b0;
      cap_bg_q   <= 1'b0;
      cap_bank_q <= 2'd0;
      cap_row_q  <= 3'd0;
      cap_col_q  <= 3'd0;
      cap_bl_q   <= 3'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cke_q      <= 1'b1;
      if (accept) begin
        cap_rwb_q  <= req_rwb;
        cap_bg_q   <= req_bank_grp;
        cap_bank_q <= req_bank_no;
        cap_row_q  <= req_row;
        cap_col_q  <= req_col;
        cap_bl_q   <= req_burst_len;
      end
      rd_valid_q <= (state_q == StRdXfer);
      rd_data_q  <= (state_q == StRdXfer) ? dataout : 16'd0;
    end
  end

  // Open-row table
  always_ff @(posedge clk_t or posedge reset) begin
    if (reset) begin
      open_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        row_q[i] <= 3'd0;
      end
    end else begin
      if (state_q == StPre) begin
        open_q[cap_idx] <= 1'b0;
      end else if (state_q == StAct) begin
        open_q[cap_idx] <= 1'b1;
        row_q[cap_idx]  <= cap_row_q;
      end else if (state_q == StCmd && AutoPre) begin
        open_q[cap_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
module tb_ram_cmd_sequencer;

  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int RL   = 3;

`ifdef RAM_AUTO_PRE_EN
  localparam bit AutoPre = 1'b1;
`else
  localparam bit AutoPre = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rwb, req_bank_grp;
  logic [1:0]  req_bank_no;
  logic [2:0]  req_row, req_col, req_burst_len;
  logic        wr_pull, rd_valid;
  logic [15:0] wr_data, rd_data, datain, dataout;
  logic        cke, cs, act, rwb, auto_pre, bank_grp, burst_mode;
  logic [1:0]  bank_no;
  logic [2:0]  row_address, col_address, burst_len;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-stamped host/RAM data so every beat value pins down its timing
  assign wr_data = 16'hB000 + cyc[15:0];
  assign dataout = 16'hD000 + cyc[15:0];

  ram_cmd_sequencer #(.TRCD(TRCD), .TRP(TRP), .RL(RL)) dut (
    .clk_t(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rwb(req_rwb),
    .req_bank_grp(req_bank_grp), .req_bank_no(req_bank_no), .req_row(req_row),
    .req_col(req_col), .req_burst_len(req_burst_len),
    .wr_pull(wr_pull), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .cke(cke), .cs(cs), .act(act), .rwb(rwb), .auto_pre(auto_pre),
    .bank_grp(bank_grp), .burst_mode(burst_mode), .bank_no(bank_no),
    .row_address(row_address), .col_address(col_address), .burst_len(burst_len),
    .datain(datain), .dataout(dataout)
  );

  typedef struct {
    int         cyc;
    logic       rwb, ap, bm, bg;
    logic [1:0] bank;
    logic [2:0] row, col, bl;
  } ev_t;

  ev_t         pre_q[$], act_q[$], cmd_q[$];
  int          wr_cyc_q[$], rd_cyc_q[$];
  logic [15:0] wr_dat_q[$], rd_dat_q[$];

  always @(negedge clk) begin
    ev_t e;
    e.cyc = cyc; e.rwb = rwb; e.ap = auto_pre; e.bm = burst_mode; e.bg = bank_grp;
    e.bank = bank_no; e.row = row_address; e.col = col_address; e.bl = burst_len;
    if (cs && act && auto_pre)  pre_q.push_back(e);
    if (cs && act && !auto_pre) act_q.push_back(e);
    if (cs && !act)             cmd_q.push_back(e);
    if (wr_pull) begin wr_cyc_q.push_back(cyc); wr_dat_q.push_back(datain); end
    if (rd_valid) begin rd_cyc_q.push_back(cyc); rd_dat_q.push_back(rd_data); end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send(input logic rw, input logic bg, input logic [1:0] bk,
                      input logic [2:0] row, input logic [2:0] col, input logic [2:0] bl,
                      output int cap);
    req_rwb = rw; req_bank_grp = bg; req_bank_no = bk;
    req_row = row; req_col = col; req_burst_len = bl;
    req_valid = 1'b1;
    cap = -1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin cap = cyc; break; end
      @(negedge clk);
    end
    if (cap < 0) check_eq("accept_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int rdy);
    rdy = -1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin rdy = cyc; break; end
      @(negedge clk);
    end
    if (rdy < 0) check_eq("ready_timeout", 0, 1);
  endtask

  task automatic run_txn(input string tag, input logic rw, input logic bg, input logic [1:0] bk,
                         input logic [2:0] row, input logic [2:0] col, input logic [2:0] bl,
                         input int exp_npre, input int exp_nact);
    int p0, a0, c0, w0, r0, t, rdy, ce, nb, endc;
    p0 = pre_q.size(); a0 = act_q.size(); c0 = cmd_q.size();
    w0 = wr_cyc_q.size(); r0 = rd_cyc_q.size();
    send(rw, bg, bk, row, col, bl, t);
    wait_ready(rdy);
    repeat (3) @(negedge clk);
    ce = t + 1 + exp_npre * TRP + exp_nact * TRCD;
    nb = int'(bl) + 1;
    check_eq({tag, "_npre"}, pre_q.size() - p0, exp_npre);
    if (exp_npre > 0 && pre_q.size() > p0) check_eq({tag, "_pre_cyc"}, pre_q[p0].cyc - t, 1);
    check_eq({tag, "_nact"}, act_q.size() - a0, exp_nact);
    if (exp_nact > 0 && act_q.size() > a0) begin
      check_eq({tag, "_act_cyc"}, act_q[a0].cyc - t, 1 + exp_npre * TRP);
      check_eq({tag, "_act_row"}, int'(act_q[a0].row), int'(row));
      check_eq({tag, "_act_bank"}, int'({act_q[a0].bg, act_q[a0].bank}), int'({bg, bk}));
    end
    check_eq({tag, "_ncmd"}, cmd_q.size() - c0, 1);
    if (cmd_q.size() > c0) begin
      check_eq({tag, "_cmd_cyc"}, cmd_q[c0].cyc - t, ce - t);
      check_eq({tag, "_cmd_rwb"}, int'(cmd_q[c0].rwb), int'(rw));
      check_eq({tag, "_cmd_ap"}, int'(cmd_q[c0].ap), int'(AutoPre));
      check_eq({tag, "_cmd_col"}, int'(cmd_q[c0].col), int'(col));
      check_eq({tag, "_cmd_bl"}, int'(cmd_q[c0].bl), int'(bl));
      check_eq({tag, "_cmd_bm"}, int'(cmd_q[c0].bm), (bl != 3'd0) ? 1 : 0);
      check_eq({tag, "_cmd_addr"}, int'({cmd_q[c0].bg, cmd_q[c0].bank, cmd_q[c0].row}),
               int'({bg, bk, row}));
    end
    if (!rw) begin
      check_eq({tag, "_nwr"}, wr_cyc_q.size() - w0, nb);
      check_eq({tag, "_nrd"}, rd_cyc_q.size() - r0, 0);
      for (int i = 0; i < nb; i++) begin
        if (w0 + i < wr_cyc_q.size()) begin
          check_eq({tag, "_wr_cyc"}, wr_cyc_q[w0 + i] - t, ce + i - t);
          check_eq({tag, "_wr_dat"}, int'(wr_dat_q[w0 + i]), int'(16'hB000 + 16'(ce + i)));
        end
      end
      endc = ce + int'(bl);
    end else begin
      check_eq({tag, "_nrd"}, rd_cyc_q.size() - r0, nb);
      check_eq({tag, "_nwr"}, wr_cyc_q.size() - w0, 0);
      for (int i = 0; i < nb; i++) begin
        if (r0 + i < rd_cyc_q.size()) begin
          check_eq({tag, "_rd_cyc"}, rd_cyc_q[r0 + i] - t, ce + RL + 1 + i - t);
          check_eq({tag, "_rd_dat"}, int'(rd_dat_q[r0 + i]), int'(16'hD000 + 16'(ce + RL + i)));
        end
      end
      endc = ce + RL + int'(bl);
    end
    check_eq({tag, "_ready"}, rdy - t, endc + 1 + (AutoPre ? TRP : 0) - t);
  endtask

  initial begin
    int t, r0, c0, seen;
    reset = 1'b1; req_valid = 1'b0; req_rwb = 1'b0; req_bank_grp = 1'b0;
    req_bank_no = 2'd0; req_row = 3'd0; req_col = 3'd0; req_burst_len = 3'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_cke", int'(cke), 0);
    check_eq("rst_ready", int'(req_ready), 0);
    check_eq("rst_cmd", int'({cs, act, rwb, auto_pre, wr_pull, rd_valid}), 0);
    check_eq("rst_data", int'({datain, rd_data}), 0);
    check_eq("rst_addr", int'({bank_grp, bank_no, row_address, col_address, burst_len}), 0);
    reset = 1'b0;
    #1;
    check_eq("rel_cke_pre_edge", int'(cke), 0);
    check_eq("rel_ready_pre_edge", int'(req_ready), 0);
    @(negedge clk);
    check_eq("rel_cke", int'(cke), 1);
    check_eq("rel_ready", int'(req_ready), 1);

    // Closed bank write, row-hit read, row-miss single-beat read
    run_txn("w1", 1'b0, 1'b0, 2'd2, 3'd5, 3'd1, 3'd3, 0, 1);
    run_txn("r1", 1'b1, 1'b0, 2'd2, 3'd5, 3'd4, 3'd3, 0, AutoPre ? 1 : 0);
    run_txn("r2", 1'b1, 1'b0, 2'd2, 3'd6, 3'd7, 3'd0, AutoPre ? 0 : 1, 1);

    // Reset while the second read beat is on the bus
    send(1'b1, 1'b0, 2'd2, 3'd6, 3'd0, 3'd3, t);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check_eq("mid_first_beat_seen", seen, 1);
    @(negedge clk);
    check_eq("mid_second_beat", int'(rd_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_rd_valid", int'(rd_valid), 0);
    check_eq("mid_rst_rd_data", int'(rd_data), 0);
    check_eq("mid_rst_ready", int'({req_ready, cke, cs}), 0);
    r0 = rd_cyc_q.size(); c0 = cmd_q.size();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_no_more_beats", rd_cyc_q.size() - r0, 0);
    check_eq("mid_no_more_cmds", cmd_q.size() - c0, 0);
    run_txn("after_rst", 1'b1, 1'b0, 2'd2, 3'd6, 3'd0, 3'd1, 0, 1);

    // Single-beat write at max row/col, then two writes to one bank/row
    run_txn("w2", 1'b0, 1'b1, 2'd3, 3'd7, 3'd7, 3'd0, 0, 1);
    run_txn("w3", 1'b0, 1'b1, 2'd0, 3'd3, 3'd2, 3'd1, 0, 1);
    run_txn("w4", 1'b0, 1'b1, 2'd0, 3'd3, 3'd5, 3'd2, 0, AutoPre ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
